// File: rtl/serial_adder_if.sv
// serial_adder_if -- handshake and operand bundle for the bit-serial adder.
//
// Signals:
//   start : request to begin an addition (sampled by the adder only when idle)
//   a, b  : WIDTH-bit operands, captured when start is accepted
//   cin   : carry-in, captured when start is accepted
//   busy  : addition in progress
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered (a+b+cin) mod 2^WIDTH
//   cout  : registered carry-out
//
// Modports:
//   master : the requester (drives start/a/b/cin, observes results)
//   slave  : the adder itself
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder, one operand bit per clock, LSB first.
//
// Contains the one-bit full_adder2 cell and the serial_adder top.
//
// serial_adder ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout out)
//
// full_adder2 ports:
//   i_a, i_b, i_c : addend bits and carry-in
//   o_s, o_c      : sum bit and carry-out

module full_adder2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

// FSM states:
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for start; operands captured on accept
//   ST_SHIFT | one bit added per cycle, counter tracks the bit
//   ST_DONE  | result registered, done pulses, back to idle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_result_nxt;

  full_adder2 u_fa (
    .i_a (r_op_a[0]),
    .i_b (r_op_b[0]),
    .i_c (r_carry),
    .o_s (w_fa_sum),
    .o_c (w_fa_carry)
  );

  assign w_last = (r_cnt == LAST_CNT);

  // Sum bit enters at the MSB; after WIDTH shifts bit 0 of the operands
  // has travelled down to bit 0 of the result.
  assign w_result_nxt = WIDTH'({w_fa_sum, r_result} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_op_a   <= r_op_a >> 1;
          r_op_b   <= r_op_b >> 1;
          r_result <= w_result_nxt;
          r_carry  <= w_fa_carry;
          // The final bit's result goes straight to the outputs so they
          // are valid in the same cycle done is high. The counter holds
          // on the last bit instead of wrapping.
          if (w_last) begin
            r_sum  <= w_result_nxt;
            r_cout <= w_fa_carry;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- scoreboard bench for serial_adder (WIDTH = 8).
// Stimulus pushes the expected {cout,sum} when it issues an operation; a
// separate monitor pops and compares on every done pulse.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int done_seen = 0;
  logic [W:0] sb_q[$];
  logic [W:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_seen++;
      n_chk++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got {cout,sum}=0x%0h with no expected result queued", {bus.cout, bus.sum});
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        if ({bus.cout, bus.sum} !== e) begin
          n_err++;
          $display("FAIL result: got {cout,sum}=0x%0h expected 0x%0h", {bus.cout, bus.sum}, e);
        end
      end
    end
  end

  // Drive an operation at the current negedge; accepted at the next posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W:0] exp);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.start = 1'b1;
    sb_q.push_back(exp);
  endtask

  // Follow one operation from acceptance to return to idle. With hold set,
  // start stays high throughout and the operands change at cycle 3.
  task automatic measure(input logic [W:0] exp, input bit hold);
    int cyc;
    int busy_n;
    int done_at;
    int d0;
    bit hold_ok;
    busy_n = 0;
    done_at = 0;
    d0 = done_seen;
    hold_ok = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    cyc = 1;
    while (bus.busy === 1'b1 && cyc < 64) begin
      busy_n++;
      if (bus.done === 1'b1) begin
        done_at = cyc;
        bus.start = 1'b0;
      end else if ({bus.cout, bus.sum} !== last_exp) begin
        hold_ok = 1'b0;
      end
      if (hold && cyc == 3) begin
        bus.a = 8'h55;
        bus.b = 8'h66;
        bus.cin = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("timeout", 32'(cyc >= 64), 32'd0);
    check("busy_cycles", 32'(busy_n), 32'(W + 1));
    check("done_latency", 32'(done_at), 32'(W + 1));
    check("done_pulses", 32'(done_seen - d0), 32'd1);
    check("shift_hold", 32'(hold_ok), 32'd1);
    check("idle_result", 32'({bus.cout, bus.sum}), 32'(exp));
    last_exp = exp;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W:0] exp);
    @(negedge clk);
    issue(a, b, cin, exp);
    measure(exp, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    // Reset with start asserted: reset wins.
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(bus.busy), 32'd0);

    run_op(8'h3C, 8'h45, 1'b0, 9'h081);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100);
    run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Start held through the whole operation, operands changed mid-way.
    @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, 9'h046);
    measure(9'h046, 1'b1);
    @(negedge clk);
    check("no_restart", 32'(bus.busy), 32'd0);
    run_op(8'h55, 8'h66, 1'b0, 9'h0BB);

    // Reset during SHIFT cycle 4: no done, outputs cleared.
    @(negedge clk);
    bus.a = 8'hAA;
    bus.b = 8'h11;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    last_exp = '0;
    rst = 1'b0;
    issue(8'h10, 8'h20, 1'b0, 9'h030);
    measure(9'h030, 1'b0);

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
